ysyx_axi4_sram_slave: RTL and testbench

//  AXI4 responder (subordinate) on the other end of the core's AXI4 master bus: independent read/write

---
 rtl/ysyx_axi4_sram_slave_pkg.sv | 25 ++
 rtl/ysyx_axi4_sram_slave_if.sv | 51 +++++
 rtl/ysyx_axi4_sram_slave_lfsr.sv | 24 ++
 rtl/ysyx_axi4_sram_slave.sv | 301 ++++++++++++++++++++++++++++++
 tb/tb_ysyx_axi4_sram_slave.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ysyx_axi4_sram_slave_pkg.sv
// Shared AXI4 constants, FSM state types and the burst-legality helper for the SRAM slave.
package ysyx_axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {R_IDLE = 2'b00, R_WAIT = 2'b01, R_DATA = 2'b10} rd_state_t;
  typedef enum logic [1:0] {W_IDLE = 2'b00, W_DATA = 2'b01, W_RESP = 2'b10} wr_state_t;

  // Only FIXED and INCR are served; WRAP and the reserved encoding answer SLVERR.
  function automatic logic burst_ok(input logic [1:0] burst);
    logic ok;
    case (burst)
      BURST_FIXED, BURST_INCR: ok = 1'b1;
      BURST_WRAP:              ok = 1'b0;
      default:                 ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/ysyx_axi4_sram_slave_if.sv
// AXI4 bus bundle between the core's master port and the SRAM slave.
interface ysyx_axi4_sram_slave_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
);
  logic [1:0]          arburst;
  logic [2:0]          arsize;
  logic [7:0]          arlen;
  logic [3:0]          arid;
  logic [ADDR_W-1:0]   araddr;
  logic                arvalid;
  logic                arready;
  logic [3:0]          rid;
  logic                rlast;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;
  logic [1:0]          awburst;
  logic [2:0]          awsize;
  logic [7:0]          awlen;
  logic [3:0]          awid;
  logic [ADDR_W-1:0]   awaddr;
  logic                awvalid;
  logic                awready;
  logic                wlast;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [3:0]          bid;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  modport slave (
    input  arburst, arsize, arlen, arid, araddr, arvalid, rready,
    input  awburst, awsize, awlen, awid, awaddr, awvalid,
    input  wlast, wdata, wstrb, wvalid, bready,
    output arready, rid, rlast, rdata, rresp, rvalid,
    output awready, wready, bid, bresp, bvalid
  );

  modport master (
    output arburst, arsize, arlen, arid, araddr, arvalid, rready,
    output awburst, awsize, awlen, awid, awaddr, awvalid,
    output wlast, wdata, wstrb, wvalid, bready,
    input  arready, rid, rlast, rdata, rresp, rvalid,
    input  awready, wready, bid, bresp, bvalid
  );
endinterface

// File: rtl/ysyx_axi4_sram_slave_lfsr.sv
// 20-bit Fibonacci LFSR (seed 1, taps 19/16) that paces the slave's random stall cycles.
module ysyx_axi_lfsr (
  input  logic       clk,
  input  logic       rst,
  output logic [3:0] lfsr_o
);
  logic [19:0] lfsr_q, lfsr_d;

  // Advance one step every cycle.
  always_comb begin
    lfsr_d = {lfsr_q[18:0], lfsr_q[19] ^ lfsr_q[16]};
  end

  // State register, reseeded on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= 20'd1;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign lfsr_o = lfsr_q[3:0];
endmodule

// File: rtl/ysyx_axi4_sram_slave.sv
// AXI4 slave onto a 64-bit synchronous SRAM with independent read/write FSMs.
// Define YSYX_AXI_SLAVE_DELAY_EN to add LFSR-driven random wait states.
module ysyx_axi4_sram_slave
  import ysyx_axi_pkg::*;
#(
  parameter int              ADDR_W    = 32,
  parameter int              DATA_W    = 64,
  parameter logic [ADDR_W-1:0] MEM_BASE = 32'h8000_0000,
  parameter int              MEM_WORDS = 4096
) (
  input logic clk,
  input logic rst,
  ysyx_axi4_sram_slave_if.slave bus
);
  localparam int                STRB_W    = DATA_W / 8;
  localparam int                IDX_W     = $clog2(MEM_WORDS);
  localparam logic [ADDR_W-1:0] MEM_BYTES = ADDR_W'(MEM_WORDS * 8);

  logic [DATA_W-1:0] mem [0:MEM_WORDS-1];

  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a,
                                                  input logic [2:0] sz, input logic [1:0] b);
    if (b == BURST_INCR) begin
      return a + (ADDR_W'(1) << sz);
    end else begin
      return a;
    end
  endfunction

  rd_state_t         rd_state_q, rd_state_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d, rd_off_s;
  logic [7:0]        rd_len_q, rd_len_d, rd_beat_q, rd_beat_d;
  logic [2:0]        rd_size_q, rd_size_d;
  logic [1:0]        rd_burst_q, rd_burst_d, rresp_q, rresp_d;
  logic [3:0]        rid_q, rid_d;
  logic              rvalid_q, rvalid_d, rlast_q, rlast_d, rd_load_s, rd_ok_s, arready_s;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  wr_state_t         wr_state_q, wr_state_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d, wr_off_s;
  logic [7:0]        wr_len_q, wr_len_d, wr_beat_q, wr_beat_d;
  logic [2:0]        wr_size_q, wr_size_d;
  logic [1:0]        wr_burst_q, wr_burst_d, bresp_q, bresp_d;
  logic [3:0]        wr_id_q, wr_id_d, bid_q, bid_d;
  logic              wr_err_q, wr_err_d, wready_q, wready_d, bvalid_q, bvalid_d;
  logic              wr_ok_s, wr_we_s, wr_end_s, wready_s, awready_s;
  logic [IDX_W-1:0]  wr_idx_s;

`ifdef YSYX_AXI_SLAVE_DELAY_EN
  logic [3:0] lfsr_s, rd_wait_q, rd_wait_d, b_wait_q, b_wait_d;
  ysyx_axi_lfsr u_lfsr (.clk(clk), .rst(rst), .lfsr_o(lfsr_s));
  assign wready_s = wready_q & lfsr_s[0];
`else
  assign wready_s = wready_q;
`endif

  assign arready_s = (rd_state_q == R_IDLE) && !rst;
  assign awready_s = (wr_state_q == W_IDLE) && !rst;

  // Read FSM next state; a "load" fetches the beat at rd_addr_d into the R registers.
  always_comb begin
    rd_state_d = rd_state_q;
    rd_addr_d  = rd_addr_q;
    rd_len_d   = rd_len_q;
    rd_beat_d  = rd_beat_q;
    rd_size_d  = rd_size_q;
    rd_burst_d = rd_burst_q;
    rid_d      = rid_q;
    rvalid_d   = rvalid_q;
    rlast_d    = rlast_q;
    rresp_d    = rresp_q;
    rdata_d    = rdata_q;
    rd_load_s  = 1'b0;
`ifdef YSYX_AXI_SLAVE_DELAY_EN
    rd_wait_d  = rd_wait_q;
`endif
    case (rd_state_q)
      R_IDLE: begin
        if (bus.arvalid && arready_s) begin
          rd_addr_d  = bus.araddr;
          rd_len_d   = bus.arlen;
          rd_size_d  = bus.arsize;
          rd_burst_d = bus.arburst;
          rid_d      = bus.arid;
          rd_beat_d  = 8'd0;
`ifdef YSYX_AXI_SLAVE_DELAY_EN
          rd_wait_d = lfsr_s;
          if (lfsr_s != 4'd0) begin
            rd_state_d = R_WAIT;
          end else begin
            rd_state_d = R_DATA;
            rd_load_s  = 1'b1;
          end
`else
          rd_state_d = R_DATA;
          rd_load_s  = 1'b1;
`endif
        end else begin
          rd_state_d = R_IDLE;
        end
      end
`ifdef YSYX_AXI_SLAVE_DELAY_EN
      R_WAIT: begin
        if (rd_wait_q <= 4'd1) begin
          rd_state_d = R_DATA;
          rd_load_s  = 1'b1;
        end else begin
          rd_wait_d = rd_wait_q - 4'd1;
        end
      end
`endif
      R_DATA: begin
        if (bus.rready && rlast_q) begin
          rd_state_d = R_IDLE;
          rvalid_d   = 1'b0;
          rlast_d    = 1'b0;
        end else if (bus.rready) begin
          rd_beat_d = rd_beat_q + 8'd1;
          rd_addr_d = next_addr(rd_addr_q, rd_size_q, rd_burst_q);
          rd_load_s = 1'b1;
        end else begin
          rd_state_d = R_DATA;
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
    rd_off_s = rd_addr_d - MEM_BASE;
    rd_ok_s  = (rd_off_s < MEM_BYTES) && burst_ok(rd_burst_d);
    if (rd_load_s) begin
      rvalid_d = 1'b1;
      rlast_d  = (rd_beat_d == rd_len_d);
      rresp_d  = rd_ok_s ? RESP_OKAY : RESP_SLVERR;
      rdata_d  = rd_ok_s ? mem[rd_off_s[IDX_W+2:3]] : '0;
    end else begin
      rdata_d = rdata_q;
    end
  end

  // Write FSM next state; error flag accumulates range, burst and wlast mismatches.
  always_comb begin
    wr_state_d = wr_state_q;
    wr_addr_d  = wr_addr_q;
    wr_len_d   = wr_len_q;
    wr_beat_d  = wr_beat_q;
    wr_size_d  = wr_size_q;
    wr_burst_d = wr_burst_q;
    wr_id_d    = wr_id_q;
    wr_err_d   = wr_err_q;
    wready_d   = wready_q;
    bvalid_d   = bvalid_q;
    bid_d      = bid_q;
    bresp_d    = bresp_q;
    wr_we_s    = 1'b0;
    wr_end_s   = bus.wlast || (wr_beat_q == wr_len_q);
    wr_off_s   = wr_addr_q - MEM_BASE;
    wr_idx_s   = wr_off_s[IDX_W+2:3];
    wr_ok_s    = (wr_off_s < MEM_BYTES) && burst_ok(wr_burst_q);
`ifdef YSYX_AXI_SLAVE_DELAY_EN
    b_wait_d   = b_wait_q;
`endif
    case (wr_state_q)
      W_IDLE: begin
        if (bus.awvalid && awready_s) begin
          wr_addr_d  = bus.awaddr;
          wr_len_d   = bus.awlen;
          wr_size_d  = bus.awsize;
          wr_burst_d = bus.awburst;
          wr_id_d    = bus.awid;
          wr_beat_d  = 8'd0;
          wr_err_d   = 1'b0;
          wready_d   = 1'b1;
          wr_state_d = W_DATA;
        end else begin
          wr_state_d = W_IDLE;
        end
      end
      W_DATA: begin
        if (bus.wvalid && wready_s) begin
          wr_we_s  = wr_ok_s;
          wr_err_d = wr_err_q || !wr_ok_s || (bus.wlast != (wr_beat_q == wr_len_q));
          if (wr_end_s) begin
            wr_state_d = W_RESP;
            wready_d   = 1'b0;
            bid_d      = wr_id_q;
            bresp_d    = wr_err_d ? RESP_SLVERR : RESP_OKAY;
`ifdef YSYX_AXI_SLAVE_DELAY_EN
            b_wait_d = lfsr_s;
            bvalid_d = (lfsr_s == 4'd0);
`else
            bvalid_d = 1'b1;
`endif
          end else begin
            wr_beat_d = wr_beat_q + 8'd1;
            wr_addr_d = next_addr(wr_addr_q, wr_size_q, wr_burst_q);
          end
        end else begin
          wr_state_d = W_DATA;
        end
      end
      W_RESP: begin
        if (bvalid_q && bus.bready) begin
          wr_state_d = W_IDLE;
          bvalid_d   = 1'b0;
        end else if (bvalid_q) begin
          wr_state_d = W_RESP;
`ifdef YSYX_AXI_SLAVE_DELAY_EN
        end else if (b_wait_q > 4'd1) begin
          b_wait_d = b_wait_q - 4'd1;
`endif
        end else begin
          bvalid_d = 1'b1;
        end
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  // Channel state registers; memory contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state_q <= R_IDLE;
      rd_addr_q  <= '0;
      rd_len_q   <= 8'd0;
      rd_beat_q  <= 8'd0;
      rd_size_q  <= 3'd0;
      rd_burst_q <= 2'd0;
      rid_q      <= 4'd0;
      rvalid_q   <= 1'b0;
      rlast_q    <= 1'b0;
      rresp_q    <= 2'd0;
      rdata_q    <= '0;
      wr_state_q <= W_IDLE;
      wr_addr_q  <= '0;
      wr_len_q   <= 8'd0;
      wr_beat_q  <= 8'd0;
      wr_size_q  <= 3'd0;
      wr_burst_q <= 2'd0;
      wr_id_q    <= 4'd0;
      wr_err_q   <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bid_q      <= 4'd0;
      bresp_q    <= 2'd0;
`ifdef YSYX_AXI_SLAVE_DELAY_EN
      rd_wait_q  <= 4'd0;
      b_wait_q   <= 4'd0;
`endif
    end else begin
      rd_state_q <= rd_state_d;
      rd_addr_q  <= rd_addr_d;
      rd_len_q   <= rd_len_d;
      rd_beat_q  <= rd_beat_d;
      rd_size_q  <= rd_size_d;
      rd_burst_q <= rd_burst_d;
      rid_q      <= rid_d;
      rvalid_q   <= rvalid_d;
      rlast_q    <= rlast_d;
      rresp_q    <= rresp_d;
      rdata_q    <= rdata_d;
      wr_state_q <= wr_state_d;
      wr_addr_q  <= wr_addr_d;
      wr_len_q   <= wr_len_d;
      wr_beat_q  <= wr_beat_d;
      wr_size_q  <= wr_size_d;
      wr_burst_q <= wr_burst_d;
      wr_id_q    <= wr_id_d;
      wr_err_q   <= wr_err_d;
      wready_q   <= wready_d;
      bvalid_q   <= bvalid_d;
      bid_q      <= bid_d;
      bresp_q    <= bresp_d;
`ifdef YSYX_AXI_SLAVE_DELAY_EN
      rd_wait_q  <= rd_wait_d;
      b_wait_q   <= b_wait_d;
`endif
    end
  end

  // Byte-lane SRAM write; a read of the same word in this cycle still sees the old value.
  always_ff @(posedge clk) begin
    if (wr_we_s && !rst) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (bus.wstrb[i]) begin
          mem[wr_idx_s][8*i +: 8] <= bus.wdata[8*i +: 8];
        end
      end
    end
  end

  assign bus.arready = arready_s;
  assign bus.rvalid  = rvalid_q;
  assign bus.rlast   = rlast_q;
  assign bus.rdata   = rdata_q;
  assign bus.rresp   = rresp_q;
  assign bus.rid     = rid_q;
  assign bus.awready = awready_s;
  assign bus.wready  = wready_s;
  assign bus.bvalid  = bvalid_q;
  assign bus.bid     = bid_q;
  assign bus.bresp   = bresp_q;
endmodule

// File: tb/tb_ysyx_axi4_sram_slave.sv
// Directed bench for ysyx_axi4_sram_slave: read vector table plus hand-written write/reset/collision sequences.
module tb_ysyx_axi4_sram_slave;
  import ysyx_axi_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ysyx_axi4_sram_slave_if #(.ADDR_W(32), .DATA_W(64)) bus ();

  ysyx_axi4_sram_slave #(
    .ADDR_W(32), .DATA_W(64), .MEM_BASE(32'h8000_0000), .MEM_WORDS(4096)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  localparam logic [63:0] W0   = 64'h1122334455667788;
  localparam logic [63:0] W1   = 64'h0123456789ABCDEF;
  localparam logic [63:0] W2   = 64'hDEADBEEFCAFEF00D;
  localparam logic [63:0] W3   = 64'h0F1E2D3C4B5A6978;
  localparam logic [63:0] W4   = 64'hA5A5A5A55A5A5A5A;
  localparam logic [63:0] W5   = 64'h1357924680ACE024;
  localparam logic [63:0] W6   = 64'h6666666677777777;
  localparam logic [63:0] W7   = 64'h8888888899999999;
  localparam logic [63:0] W1N  = 64'hAABBCCDD89ABCDEF;
  localparam logic [63:0] W4N  = 64'h4444000044440000;
  localparam logic [63:0] W5N  = 64'h5555000055550000;
  localparam logic [63:0] W7N  = 64'h8888888877770000;
  localparam logic [63:0] WTOP = 64'hFEEDFACE12345678;
  localparam logic [63:0] WC   = 64'h2222333344445555;
  localparam logic [1:0]  OK   = 2'b00;
  localparam logic [1:0]  SE   = 2'b10;

  typedef struct {
    logic [31:0]      addr;
    logic [7:0]       len;
    logic [2:0]       size;
    logic [1:0]       burst;
    logic [3:0]       id;
    logic             toggle;
    logic [3:0][63:0] exp_d;
    logic [3:0][1:0]  exp_r;
  } rd_vec_t;

  int tests = 0;
  int fails = 0;
  rd_vec_t vt [10];
  logic [63:0] init_w [8];

  function automatic rd_vec_t mk(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s,
                                 input logic [1:0] b, input logic [3:0] id, input logic t,
                                 input logic [63:0] d0, input logic [63:0] d1,
                                 input logic [63:0] d2, input logic [63:0] d3,
                                 input logic [1:0] r0, input logic [1:0] r1,
                                 input logic [1:0] r2, input logic [1:0] r3);
    rd_vec_t v;
    v.addr = a; v.len = l; v.size = s; v.burst = b; v.id = id; v.toggle = t;
    v.exp_d[0] = d0; v.exp_d[1] = d1; v.exp_d[2] = d2; v.exp_d[3] = d3;
    v.exp_r[0] = r0; v.exp_r[1] = r1; v.exp_r[2] = r2; v.exp_r[3] = r3;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic aw_req(input logic [31:0] a, input logic [7:0] l, input logic [3:0] id,
                        input logic [2:0] s, input logic [1:0] b);
    int n = 0;
    bus.awaddr = a; bus.awlen = l; bus.awid = id; bus.awsize = s; bus.awburst = b;
    bus.awvalid = 1'b1;
    while (!bus.awready && n < 50) begin tick(); n++; end
    chk("awready", 64'(bus.awready), 64'd1);
    tick();
    bus.awvalid = 1'b0;
  endtask

  task automatic ar_req(input logic [31:0] a, input logic [7:0] l, input logic [3:0] id,
                        input logic [2:0] s, input logic [1:0] b);
    int n = 0;
    bus.araddr = a; bus.arlen = l; bus.arid = id; bus.arsize = s; bus.arburst = b;
    bus.arvalid = 1'b1;
    while (!bus.arready && n < 50) begin tick(); n++; end
    chk("arready", 64'(bus.arready), 64'd1);
    tick();
    bus.arvalid = 1'b0;
  endtask

  task automatic w_beat(input logic [63:0] d, input logic [7:0] strb, input logic last);
    int n = 0;
    bus.wdata = d; bus.wstrb = strb; bus.wlast = last; bus.wvalid = 1'b1;
    while (!bus.wready && n < 50) begin tick(); n++; end
    chk("wready", 64'(bus.wready), 64'd1);
    tick();
    bus.wvalid = 1'b0;
    bus.wlast  = 1'b0;
  endtask

  // Called right after the final W handshake: response must already be up.
  task automatic b_resp(input string name, input logic [3:0] id, input logic [1:0] resp);
    chk({name, "_bvalid"}, 64'(bus.bvalid), 64'd1);
    chk({name, "_wready_off"}, 64'(bus.wready), 64'd0);
    chk({name, "_bid"}, 64'(bus.bid), 64'(id));
    chk({name, "_bresp"}, 64'(bus.bresp), 64'(resp));
    bus.bready = 1'b1;
    tick();
    bus.bready = 1'b0;
    chk({name, "_bdone"}, 64'(bus.bvalid), 64'd0);
  endtask

  task automatic run_rd(input string name, input rd_vec_t v);
    int  beat = 0;
    int  n    = 0;
    logic hs;
    ar_req(v.addr, v.len, v.id, v.size, v.burst);
    chk({name, "_rlat"}, 64'(bus.rvalid), 64'd1);
    while (beat <= int'(v.len) && n < 40) begin
      bus.rready = v.toggle ? (n % 2 == 0) : 1'b1;
      if (bus.rvalid) begin
        chk({name, "_rid"}, 64'(bus.rid), 64'(v.id));
        chk({name, "_rdata"}, bus.rdata, v.exp_d[beat]);
        chk({name, "_rresp"}, 64'(bus.rresp), 64'(v.exp_r[beat]));
        chk({name, "_rlast"}, 64'(bus.rlast), 64'(beat == int'(v.len)));
      end
      hs = bus.rvalid && bus.rready;
      tick();
      n++;
      if (hs) beat++;
    end
    bus.rready = 1'b0;
    chk({name, "_beats"}, 64'(beat), 64'(v.len) + 64'd1);
    chk({name, "_rdone"}, 64'(bus.rvalid), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.arvalid = 1'b0; bus.araddr = 32'd0; bus.arlen = 8'd0; bus.arid = 4'd0;
    bus.arsize = 3'd0; bus.arburst = 2'd0; bus.rready = 1'b0;
    bus.awvalid = 1'b0; bus.awaddr = 32'd0; bus.awlen = 8'd0; bus.awid = 4'd0;
    bus.awsize = 3'd0; bus.awburst = 2'd0;
    bus.wvalid = 1'b0; bus.wdata = 64'd0; bus.wstrb = 8'd0; bus.wlast = 1'b0;
    bus.bready = 1'b0;
    init_w = '{W0, W1, W2, W3, W4, W5, W6, W7};

    // Reset: outputs cleared, ready forced low, AR during reset ignored.
    repeat (3) tick();
    bus.araddr = 32'h8000_0000; bus.arburst = BURST_INCR; bus.arvalid = 1'b1;
    chk("rst_arready", 64'(bus.arready), 64'd0);
    chk("rst_awready", 64'(bus.awready), 64'd0);
    tick();
    bus.arvalid = 1'b0;
    chk("rst_rvalid", 64'(bus.rvalid), 64'd0);
    chk("rst_bvalid", 64'(bus.bvalid), 64'd0);
    chk("rst_wready", 64'(bus.wready), 64'd0);
    chk("rst_rdata", bus.rdata, 64'd0);
    chk("rst_rid", 64'(bus.rid), 64'd0);
    chk("rst_bid", 64'(bus.bid), 64'd0);
    rst = 1'b0;
    #1;
    chk("rel_arready", 64'(bus.arready), 64'd1);
    chk("rel_awready", 64'(bus.awready), 64'd1);
    tick();
    chk("rel_no_rvalid", 64'(bus.rvalid), 64'd0);

    // Preload words 0..7 and the last word of the range.
    aw_req(32'h8000_0000, 8'd7, 4'd0, 3'd3, BURST_INCR);
    for (int i = 0; i < 8; i++) w_beat(init_w[i], 8'hFF, i == 7);
    b_resp("pre", 4'd0, OK);
    aw_req(32'h8000_7FF8, 8'd0, 4'd1, 3'd3, BURST_INCR);
    w_beat(WTOP, 8'hFF, 1'b1);
    b_resp("pre_top", 4'd1, OK);

    // Strobed write of the upper half of word 1.
    aw_req(32'h8000_0008, 8'd0, 4'd5, 3'd3, BURST_INCR);
    w_beat(64'hAABBCCDD_00000000, 8'hF0, 1'b1);
    b_resp("strb", 4'd5, OK);

    // Error writes: out of range, early wlast, WRAP burst, missing wlast.
    aw_req(32'h9000_0000, 8'd0, 4'd2, 3'd3, BURST_INCR);
    w_beat(64'hBAD0BAD0BAD0BAD0, 8'hFF, 1'b1);
    b_resp("oor_wr", 4'd2, SE);
    aw_req(32'h8000_0020, 8'd2, 4'd6, 3'd3, BURST_INCR);
    w_beat(W4N, 8'hFF, 1'b0);
    w_beat(W5N, 8'hFF, 1'b1);
    b_resp("early_wlast", 4'd6, SE);
    aw_req(32'h8000_0030, 8'd0, 4'd7, 3'd3, BURST_WRAP);
    w_beat(64'd0, 8'hFF, 1'b1);
    b_resp("wrap_wr", 4'd7, SE);
    aw_req(32'h8000_0038, 8'd0, 4'd9, 3'd3, BURST_INCR);
    w_beat(64'h7777000077770000, 8'h0F, 1'b0);
    b_resp("late_wlast", 4'd9, SE);

    // Read vectors reflecting everything written above.
    vt[0] = mk(32'h8000_0004, 8'd0, 3'd2, BURST_INCR,  4'd3,  1'b0, W0,   64'd0, 64'd0, 64'd0, OK, OK, OK, OK);
    vt[1] = mk(32'h8000_0000, 8'd3, 3'd3, BURST_INCR,  4'd1,  1'b1, W0,   W1N,   W2,    W3,    OK, OK, OK, OK);
    vt[2] = mk(32'h8000_0010, 8'd2, 3'd3, BURST_FIXED, 4'd2,  1'b0, W2,   W2,    W2,    64'd0, OK, OK, OK, OK);
    vt[3] = mk(32'h8000_0004, 8'd1, 3'd2, BURST_INCR,  4'd4,  1'b0, W0,   W1N,   64'd0, 64'd0, OK, OK, OK, OK);
    vt[4] = mk(32'h1000_0000, 8'd1, 3'd3, BURST_INCR,  4'd6,  1'b0, 64'd0, 64'd0, 64'd0, 64'd0, SE, SE, OK, OK);
    vt[5] = mk(32'h8000_0000, 8'd1, 3'd3, BURST_WRAP,  4'd7,  1'b0, 64'd0, 64'd0, 64'd0, 64'd0, SE, SE, OK, OK);
    vt[6] = mk(32'h8000_7FF8, 8'd1, 3'd3, BURST_INCR,  4'd8,  1'b0, WTOP, 64'd0, 64'd0, 64'd0, OK, SE, OK, OK);
    vt[7] = mk(32'h7FFF_FFF8, 8'd1, 3'd3, BURST_INCR,  4'd9,  1'b1, 64'd0, W0,   64'd0, 64'd0, SE, OK, OK, OK);
    vt[8] = mk(32'h8000_0020, 8'd3, 3'd3, BURST_INCR,  4'd10, 1'b0, W4N,  W5N,   W6,    W7N,   OK, OK, OK, OK);
    vt[9] = mk(32'h8000_0008, 8'd0, 3'd3, BURST_INCR,  4'd5,  1'b0, W1N,  64'd0, 64'd0, 64'd0, OK, OK, OK, OK);
    for (int i = 0; i < 10; i++) run_rd($sformatf("vec%0d", i), vt[i]);

    // Reset while beat 2 of a len7 burst is on the bus.
    ar_req(32'h8000_0000, 8'd7, 4'd11, 3'd3, BURST_INCR);
    bus.rready = 1'b1;
    tick();
    tick();
    chk("midrst_beat2", bus.rdata, W2);
    bus.rready = 1'b0;
    rst = 1'b1;
    tick();
    chk("midrst_rvalid", 64'(bus.rvalid), 64'd0);
    chk("midrst_arready", 64'(bus.arready), 64'd0);
    rst = 1'b0;
    #1;
    chk("midrst_rel_arready", 64'(bus.arready), 64'd1);
    tick();
    run_rd("retained", mk(32'h8000_0000, 8'd1, 3'd3, BURST_INCR, 4'd12, 1'b0,
                          W0, W1N, 64'd0, 64'd0, OK, OK, OK, OK));

    // AR handshake and W commit to the same word on the same edge.
    aw_req(32'h8000_0010, 8'd0, 4'd14, 3'd3, BURST_INCR);
    bus.araddr = 32'h8000_0010; bus.arlen = 8'd0; bus.arid = 4'd13;
    bus.arsize = 3'd3; bus.arburst = BURST_INCR; bus.arvalid = 1'b1;
    bus.wdata = WC; bus.wstrb = 8'hFF; bus.wlast = 1'b1; bus.wvalid = 1'b1;
    chk("cc_arready", 64'(bus.arready), 64'd1);
    chk("cc_wready", 64'(bus.wready), 64'd1);
    tick();
    bus.arvalid = 1'b0; bus.wvalid = 1'b0; bus.wlast = 1'b0;
    chk("cc_rvalid", 64'(bus.rvalid), 64'd1);
    chk("cc_old_data", bus.rdata, W2);
    chk("cc_rid", 64'(bus.rid), 64'd13);
    chk("cc_bvalid", 64'(bus.bvalid), 64'd1);
    chk("cc_bid", 64'(bus.bid), 64'd14);
    chk("cc_bresp", 64'(bus.bresp), 64'(OK));
    bus.rready = 1'b1; bus.bready = 1'b1;
    tick();
    bus.rready = 1'b0; bus.bready = 1'b0;
    chk("cc_rdone", 64'(bus.rvalid), 64'd0);
    chk("cc_bdone", 64'(bus.bvalid), 64'd0);
    run_rd("cc_new", mk(32'h8000_0010, 8'd0, 3'd3, BURST_INCR, 4'd15, 1'b0,
                        WC, 64'd0, 64'd0, 64'd0, OK, OK, OK, OK));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
